// File: rtl/multdiv_pkg.sv
// Shared types and helpers for the multi-cycle signed multiply/divide unit.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

    // Width of the iteration counter; it must hold WIDTH-1.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/multdiv_unit_if.sv
// Operand / control / result bundle between the execute stage and multdiv_unit.
interface multdiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_addsub.sv
// Shared N-bit adder/subtractor: sum_o = a_i + b_i, or a_i - b_i when sub_i.
// carry_o is the true carry-out; on subtract it is 1 when no borrow occurred.
module multdiv_addsub #(
    parameter int N = 33
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         sub_i,
    output logic [N-1:0] sum_o,
    output logic         carry_o
);
    logic [N-1:0] b_eff;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{N{1'b0}}, sub_i};
endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply/divide unit, one bit per cycle on magnitudes.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no operation in flight; result/exception hold the last op
//   RUN   | one shift-add / restoring-subtract step per cycle, cnt_q counts down
//   DONE  | sign fix-up through the shared adder; result registered and RDY
//         | raised at the edge leaving this state
//
// hi_q/lo_q double as product high/low halves (multiply) or remainder/quotient
// (divide). mcand_q holds |A| for multiply or |B| for divide.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    multdiv_unit_if.slave bus
);
    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;
    logic             dz_q, dz_d;
    logic             dovf_q, dovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic             start;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_a, add_b, add_sum;
    logic             add_sub, add_carry;
    logic [WIDTH-1:0] fix_val;
    logic             mul_ovf;

    // Exactly one start strobe is a start; both together are ignored.
    assign start = bus.ctrl_MULT ^ bus.ctrl_DIV;

    assign a_mag = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + WIDTH'(1))
                                              : bus.data_operandA;
    assign b_mag = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + WIDTH'(1))
                                              : bus.data_operandB;

    multdiv_addsub #(
        .N(WIDTH + 1)
    ) u_addsub (
        .a_i    (add_a),
        .b_i    (add_b),
        .sub_i  (add_sub),
        .sum_o  (add_sum),
        .carry_o(add_carry)
    );

    // Steer the single adder: negate in DONE, trial subtract or accumulate in RUN.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_sub = 1'b0;
        if (state_q == DONE) begin
            add_a   = '0;
            add_b   = {1'b0, lo_q};
            add_sub = 1'b1;
        end else if (op_q == OP_DIV) begin
            add_a   = {hi_q, lo_q[WIDTH-1]};
            add_b   = {1'b0, mcand_q};
            add_sub = 1'b1;
        end else begin
            add_a   = {1'b0, hi_q};
            add_b   = lo_q[0] ? {1'b0, mcand_q} : '0;
            add_sub = 1'b0;
        end
    end

    // Signed low half / quotient, and whether the signed product overflowed.
    // A negative product of magnitude exactly MIN still fits.
    assign fix_val = neg_q ? add_sum[WIDTH-1:0] : lo_q;
    assign mul_ovf = (hi_q != '0) ||
                     (lo_q[WIDTH-1] && !(neg_q && (lo_q == MIN_VAL)));

    // Next-state, iteration datapath and result capture.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        neg_d    = neg_q;
        dz_d     = dz_q;
        dovf_d   = dovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;

        case (state_q)
            RUN: begin
                if (op_q == OP_DIV) begin
                    if (add_carry) begin
                        hi_d = add_sum[WIDTH-1:0];
                        lo_d = {lo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                        lo_d = {lo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    hi_d = add_sum[WIDTH:1];
                    lo_d = {add_sum[0], lo_q[WIDTH-1:1]};
                end
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
                if (op_q == OP_DIV) begin
                    result_d = dz_q ? '0 : fix_val;
                    exc_d    = dz_q | dovf_q;
                end else begin
                    result_d = fix_val;
                    exc_d    = mul_ovf;
                end
            end
            default: begin
            end
        endcase

        // A start wins over whatever the current state would do next; the
        // result capture above still completes if we were in DONE.
        if (start) begin
            state_d = RUN;
            op_d    = bus.ctrl_DIV ? OP_DIV : OP_MULT;
            cnt_d   = CNT_LOAD;
            hi_d    = '0;
            neg_d   = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            if (bus.ctrl_DIV) begin
                mcand_d = b_mag;
                lo_d    = a_mag;
                dz_d    = (bus.data_operandB == '0);
                dovf_d  = (bus.data_operandA == MIN_VAL) && (bus.data_operandB == '1);
            end else begin
                mcand_d = a_mag;
                lo_d    = b_mag;
                dz_d    = 1'b0;
                dovf_d  = 1'b0;
            end
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= OP_MULT;
            cnt_q    <= '0;
            mcand_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            dovf_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            neg_q    <= neg_d;
            dz_q     <= dz_d;
            dovf_q   <= dovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: doc/multdiv_unit.md
# multdiv_unit

Parametrised, multi-cycle signed multiply/divide unit that sits beside the combinational ALU in the execute stage and handles the MUL and DIV operations the ALU does not implement. Operands are latched on a start pulse. The unit iterates one bit per cycle. It then presents a WIDTH-bit result with an exception flag and a one-cycle ready strobe. Exception semantics extend the ALU's overflow flag to multiply overflow, divide-by-zero and the MIN/-1 case.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4).
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset, synchronous, active-low.
- data_operandA  in  WIDTH  multiplicand / dividend (two's complement); sampled only on start.
- data_operandB  in  WIDTH  multiplier / divisor (two's complement); sampled only on start.
- ctrl_MULT  in  1  single-cycle start pulse, multiply.
- ctrl_DIV  in  1  single-cycle start pulse, divide.
- data_result  out  WIDTH  product low half or quotient; registered; held until next start.
- data_exception  out  1  valid with data_resultRDY; held with data_result.
- data_resultRDY  out  1  one-cycle strobe: result and exception valid.
- busy  out  1  high while an operation is in flight.

## Operation
- FSM states: IDLE, RUN, DONE.
- Start = exactly one of ctrl_MULT/ctrl_DIV high at a rising edge. Both high: no start, state unchanged.
- Start from any state, including RUN, aborts the current operation (no RDY for it). It latches operands and op, loads the cycle counter with WIDTH-1 and enters RUN.
- RUN: one iteration per cycle; counter decrements. At counter==0 the final iteration plus sign fix-up completes. The FSM then enters DONE.
- DONE: results registered, RDY=1 for this cycle only, then IDLE.
- Datapath works on magnitudes: |A|, |B| via negate-if-negative. The result sign is A[W-1]^B[W-1], applied in the final cycle.
- Multiply: shift-add into 2·WIDTH accumulator; data_result = low WIDTH bits of the signed product.
  - data_exception=1 iff the true product does not fit in signed WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal.
  - Zero operand: result 0, exception 0.
- Divide: restoring division, quotient truncated toward zero; remainder discarded.
  - B==0: exception=1, result 0. Detected at start, but latency is unchanged.
  - A==MIN and B==-1: exception=1, result = MIN (0x80000000 for WIDTH=32).
- All other cases: exception 0.

## Timing
- Reset (reset_n low at an edge) forces IDLE, data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0. This applies from any state; an in-flight operation is discarded with no RDY.
- Start sampled at edge t:
  - busy=1 from t through t+WIDTH.
  - data_resultRDY=1 during the cycle after edge t+WIDTH+1 only; busy=0 in that cycle.
  - Latency is fixed at WIDTH+1 cycles for all ops and all operand values.
- data_result and data_exception change only at the DONE transition or reset. Between operations they hold the last result.
- A new start in the DONE cycle is accepted: RDY still pulses for the finished op, and the new op begins.
- Operand inputs may change freely after the start edge.

## Structure
- Package multdiv_pkg:
  - state_t enum {IDLE, RUN, DONE};
  - op_t enum {OP_MULT, OP_DIV};
  - localparam function for counter width, $clog2(WIDTH).
- Sub-module multdiv_addsub: WIDTH+1-bit add/subtract with a carry-out. Multiply uses it for accumulate, divide for trial subtract, and both for the negate/fix-up steps. One instance is shared.
- Top contains FSM, counter, operand/accumulator/quotient shift registers, and exception logic.

## Test plan
- MULT, WIDTH=32:
  - A=3, B=0xFFFFFFF9 (−7) → RDY exactly 33 cycles after start, result 0xFFFFFFEB, exception 0.
  - A=0x00010000, B=0x00010000 → exception 1.
- DIV:
  - A=0xFFFFFFEB (−21), B=4 → result 0xFFFFFFFB (−5), exception 0.
  - A=7, B=0 → result 0, exception 1, RDY still at +33.
  - A=0x80000000, B=0xFFFFFFFF → result 0x80000000, exception 1.
- Restart: MULT 5×5, then DIV 100/7 pulsed 10 cycles later → exactly one RDY, 33 cycles after the DIV pulse, result 14. No RDY for the aborted multiply.
- Reset mid-op: reset_n low for one edge at cycle 12 of a multiply → all outputs 0, busy 0, and no RDY within the next 40 cycles.
- ctrl_MULT and ctrl_DIV high together while IDLE → busy stays 0, no RDY, previous result held.
- WIDTH=8 build: −128 × 1 → result 0x80, exception 0, RDY at +9.
